uart_n: RTL and testbench
=========================

# uart_n

Parametrised full-duplex UART, successor to the fixed 8-bit 9600-baud core, used as the serial endpoint between on-board logic and external links. It adds configurable baud rate, data width, stop-bit count and optional parity, a 16x-oversampled receiver with false-start rejection, and an asynchronous active-low reset. The TX and RX halves are independent and share only the baud divider constant.

## Interface
- CLOCK_RATE, 12000000, system clock frequency in Hz
- BAUD_RATE, 9600, line rate in baud
- DATA_BITS, 8, data bits per frame, legal range 5..9
- STOP_BITS, 1, stop bits transmitted, 1 or 2
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even. Ignored unless UART_PARITY_EN is defined.
- clk  in  1  system clock, rising edge
- rstN  in  1  asynchronous active-low reset
- rxEn  in  1  receiver enable
- rxIn  in  1  serial input, asynchronous
- rxBusy  out  1  frame reception in progress
- rxDone  out  1  one-cycle pulse: rxOut, rxErr and rxParErr valid
- rxErr  out  1  framing error, stop bit sampled low
- rxParErr  out  1  parity mismatch
- rxOut  out  DATA_BITS  last received word
- txEn  in  1  transmitter enable
- txStart  in  1  request to send txIn
- txIn  in  DATA_BITS  word to send
- txBusy  out  1  frame transmission in progress
- txDone  out  1  one-cycle pulse at frame end
- txOut  out  1  serial output, idle high

## Operation
- Reset values: txOut=1. txBusy, txDone, rxBusy, rxDone, rxErr and rxParErr are all 0. rxOut=0. Both FSMs go to IDLE. Reset takes effect immediately, mid-frame included.
- Oversample divider: DIV = floor(CLOCK_RATE/(BAUD_RATE*16)), which is 78 at the defaults. One bit period is 16*DIV clocks (1248).
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if txEn and txStart, latch txIn, restart the bit timer, enter START.
  - START sends 0. DATA sends the word LSB first.
  - PARITY sends the parity bit. This state exists only if parity is compiled in and PARITY≠0.
  - STOP sends STOP_BITS high bits.
  - When STOP ends, go to IDLE with txDone=1 for one cycle.
  - If txStart is still high in that IDLE cycle, the next frame starts with no idle gap.
  - txIn is sampled only at acceptance. Changes during a frame have no effect on that frame.
  - txEn low mid-frame: abort to IDLE, txOut=1, no txDone.
- RX FSM states: IDLE, START, DATA, PARITY, STOP, WAITHI.
  - rxIn passes through a 2-flop synchronizer.
  - IDLE: a synchronized 0 with rxEn high enters START, sets rxBusy and clears rxErr and rxParErr.
  - START resamples at oversample tick 8. If the line is high, the start is false: return to IDLE with no rxDone.
  - Each later bit is sampled at tick 8 of its 16-tick period: DATA bits LSB first, then PARITY if present, then the first stop bit.
  - The stop-bit sample completes the frame in one cycle: rxOut is loaded, rxErr/rxParErr are set, rxDone pulses and rxBusy drops.
  - If stop=1, go to IDLE. If stop=0, go to WAITHI until the line is high, so a break does not retrigger.
  - The receiver checks one stop bit regardless of STOP_BITS.
  - rxOut, rxErr and rxParErr hold until the next valid start.
  - rxEn low: immediately go to IDLE, rxBusy=0, no rxDone.
- Parity is computed as the XOR of the DATA_BITS data bits. Odd mode inverts it.

## Timing
- txStart accepted at edge k: txBusy=1 and txOut=0 at edge k+1.
- Frame length F = (1+DATA_BITS+P+STOP_BITS)*16*DIV clocks, where P=1 if a parity bit is sent, else 0.
- txDone and txBusy fall at edge k+1+F.
- RX latency: rxDone asserts 2 sync cycles + 1 cycle after the stop-bit mid-sample. This is about (F_rx−0.5 bit)+3 clocks after the falling start edge at rxIn.
- Oversample ticks are phase-reset on start detection, so sample-point error is at most 1 tick.
- rxDone and txDone are never wider than one cycle.
- Simultaneous events:
  - txStart coincides with txDone: the new frame is accepted that edge.
  - rxEn falls on the rxDone cycle: rxDone still pulses.

## Configuration
- UART_PARITY_EN defined: PARITY states, the parity generator/checker and rxParErr logic are built. PARITY selects the mode.
- UART_PARITY_EN undefined: no parity bit is sent or expected, PARITY is ignored, and rxParErr is tied to 0.

## Test plan
- Loopback 8N1 at defaults, txIn=0x7A:
  - txOut low for 1248 clocks after acceptance.
  - txDone at +12481.
  - Receiver yields rxOut=0x7A, rxErr=0, rxParErr=0.
- Back-to-back: txStart held, 0x7A, then txIn=0xB1 set mid-frame.
  - First frame still sends 0x7A.
  - The second frame's start bit begins the cycle after txDone, with no high gap.
  - rxOut=0xB1 on the second rxDone.
- With UART_PARITY_EN, PARITY=2, 0xB1: the parity bit is 0 and rxParErr=0. A forced parity bit of 1 gives rxParErr=1 with rxDone, and rxOut=0xB1.
- Framing: stop bit driven 0, then line held low 3 bit times.
  - rxErr=1 on rxDone.
  - No second rxBusy until rxIn returns high, then low again.
- False start: a 300-clock low glitch on rxIn gives rxBusy for under 700 clocks, and no rxDone.
- Abort and reset:
  - txEn dropped at bit 4: txOut=1, txBusy=0, no txDone.
  - rstN pulsed low mid-RX: all outputs take their reset values asynchronously, and the next clean frame is received correctly.

Source files
------------

// File: rtl/uart_n_if.sv
// Serial-endpoint bundle for uart_n: TX request/status, RX strobe/status and FSM debug taps.
// The slave modport is the UART side, the master modport is the on-board logic side.
interface uart_n_if #(
  parameter int DATA_BITS = 8
);
  // txStart is a level request, taken on the clock edge where the transmitter is IDLE
  // and txEn is high; txIn is captured on that edge only. txBusy is high while a frame is in flight.
  // txDone and rxDone are single-cycle strobes with no backpressure. rxOut/rxErr/rxParErr are valid with rxDone.
  logic                 rxEn;
  logic                 rxIn;
  logic                 rxBusy;
  logic                 rxDone;
  logic                 rxErr;
  logic                 rxParErr;
  logic [DATA_BITS-1:0] rxOut;
  logic                 txEn;
  logic                 txStart;
  logic [DATA_BITS-1:0] txIn;
  logic                 txBusy;
  logic                 txDone;
  logic                 txOut;
  logic [2:0]           tx_state_dbg;
  logic [2:0]           rx_state_dbg;

  modport slave (
    input  rxEn, rxIn, txEn, txStart, txIn,
    output rxBusy, rxDone, rxErr, rxParErr, rxOut, txBusy, txDone, txOut,
    output tx_state_dbg, rx_state_dbg
  );

  modport master (
    output rxEn, rxIn, txEn, txStart, txIn,
    input  rxBusy, rxDone, rxErr, rxParErr, rxOut, txBusy, txDone, txOut,
    input  tx_state_dbg, rx_state_dbg
  );
endinterface

// File: rtl/uart_n.sv
// Parametrised full-duplex UART with a 16x-oversampled receiver and false-start rejection.
// Optional parity bit generation/checking is built only when UART_PARITY_EN is defined.
module uart_n #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0
) (
  input logic     clk,
  input logic     rstN,
  uart_n_if.slave bus
);

  localparam int DIV      = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int BIT_CLKS = DIV * 16;
  localparam int TCW      = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int DCW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BCW      = $clog2(DATA_BITS + 1);

  localparam logic [TCW-1:0] TX_LAST   = TCW'(BIT_CLKS - 1);
  localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

`ifdef UART_PARITY_EN
  localparam bit PAR_ON = (PARITY != 0);
`else
  localparam bit PAR_ON = 1'b0;
`endif
  localparam bit PAR_ODD = (PARITY == 1);

  // Collapses to constant 0 when no parity bit is on the line.
  function automatic logic par_of(input logic [DATA_BITS-1:0] w);
    return PAR_ON & ((^w) ^ PAR_ODD);
  endfunction

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_WAITHI = 3'd5
  } rx_state_e;

  // ---------------------------------------------------------------- transmitter
  tx_state_e            tx_state_q, tx_state_d;
  logic [TCW-1:0]       tx_cnt_q, tx_cnt_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [BCW-1:0]       tx_bit_q, tx_bit_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_out_q, tx_out_d;
  logic                 tx_done_q, tx_done_d;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == TX_LAST);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_par_q   <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_par_q   <= tx_par_d;
      tx_out_q   <= tx_out_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_par_d   = tx_par_q;
    tx_done_d  = 1'b0;
    tx_out_d   = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (bus.txEn && bus.txStart) begin
          tx_state_d = TX_START;
          tx_shift_d = bus.txIn;
          tx_par_d   = par_of(bus.txIn);
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = '0;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == DATA_LAST) begin
            tx_state_d = PAR_ON ? TX_PARITY : TX_STOP;
            tx_bit_d   = '0;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_state_d = TX_STOP;
          tx_bit_d   = '0;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_bit_q == STOP_LAST) begin
            tx_state_d = TX_IDLE;
            tx_done_d  = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Disabling the transmitter drops the frame without a completion strobe.
    if (!bus.txEn) begin
      tx_state_d = TX_IDLE;
      tx_done_d  = 1'b0;
    end
    // The line level is registered from the next state so txOut never glitches.
    case (tx_state_d)
      TX_START:  tx_out_d = 1'b0;
      TX_DATA:   tx_out_d = tx_shift_d[0];
      TX_PARITY: tx_out_d = tx_par_d;
      default:   tx_out_d = 1'b1;
    endcase
  end

  assign bus.txOut        = tx_out_q;
  assign bus.txDone       = tx_done_q;
  assign bus.txBusy       = (tx_state_q != TX_IDLE);
  assign bus.tx_state_dbg = tx_state_q;

  // ------------------------------------------------------------------- receiver
  rx_state_e            rx_state_q, rx_state_d;
  logic                 rx_meta_q, rx_sync_q;
  logic [DCW-1:0]       rx_div_q, rx_div_d;
  logic [3:0]           rx_tick_q, rx_tick_d;
  logic [BCW-1:0]       rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_bit_q, rx_par_bit_d;
  logic [DATA_BITS-1:0] rx_out_q, rx_out_d;
  logic                 rx_err_q, rx_err_d;
  logic                 rx_par_err_q, rx_par_err_d;
  logic                 rx_done_q, rx_done_d;
  logic                 rx_tick, rx_mid, rx_sample;

  assign rx_tick   = (rx_div_q == DIV_LAST);
  assign rx_mid    = rx_tick && (rx_tick_q == 4'd7);
  assign rx_sample = rx_tick && (rx_tick_q == 4'd15);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_div_q     <= '0;
      rx_tick_q    <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_bit_q <= 1'b0;
      rx_out_q     <= '0;
      rx_err_q     <= 1'b0;
      rx_par_err_q <= 1'b0;
      rx_done_q    <= 1'b0;
    end else begin
      rx_meta_q    <= bus.rxIn;
      rx_sync_q    <= rx_meta_q;
      rx_state_q   <= rx_state_d;
      rx_div_q     <= rx_div_d;
      rx_tick_q    <= rx_tick_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_bit_q <= rx_par_bit_d;
      rx_out_q     <= rx_out_d;
      rx_err_q     <= rx_err_d;
      rx_par_err_q <= rx_par_err_d;
      rx_done_q    <= rx_done_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_div_d     = rx_tick ? '0 : rx_div_q + 1'b1;
    rx_tick_d    = rx_tick ? rx_tick_q + 4'd1 : rx_tick_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_par_bit_d = rx_par_bit_q;
    rx_out_d     = rx_out_q;
    rx_err_d     = rx_err_q;
    rx_par_err_d = rx_par_err_q;
    rx_done_d    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        // Oversample phase restarts on the detected falling edge.
        rx_div_d  = '0;
        rx_tick_d = '0;
        if (bus.rxEn && !rx_sync_q) begin
          rx_state_d   = RX_START;
          rx_err_d     = 1'b0;
          rx_par_err_d = 1'b0;
        end
      end
      RX_START: begin
        if (rx_mid) begin
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_tick_d  = '0;
            rx_bit_d   = '0;
          end
        end
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == DATA_LAST) begin
            rx_state_d = PAR_ON ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_sample) begin
          rx_par_bit_d = rx_sync_q;
          rx_state_d   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_sample) begin
          rx_out_d     = rx_shift_q;
          rx_err_d     = !rx_sync_q;
          rx_par_err_d = PAR_ON & (rx_par_bit_q ^ par_of(rx_shift_q));
          rx_done_d    = 1'b1;
          rx_state_d   = rx_sync_q ? RX_IDLE : RX_WAITHI;
        end
      end
      RX_WAITHI: begin
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (!bus.rxEn) rx_state_d = RX_IDLE;
  end

  assign bus.rxOut        = rx_out_q;
  assign bus.rxErr        = rx_err_q;
  assign bus.rxParErr     = rx_par_err_q;
  assign bus.rxDone       = rx_done_q;
  assign bus.rxBusy       = (rx_state_q != RX_IDLE) && (rx_state_q != RX_WAITHI);
  assign bus.rx_state_dbg = rx_state_q;

endmodule

// File: tb/tb_uart_n.sv
// Directed bench for uart_n at 12 MHz / 9600 baud, 8 data bits, 1 stop bit (even parity when UART_PARITY_EN).
// Received words are scored against an expected queue filled whenever a frame is put on the line.
module tb_uart_n;

  localparam int BIT    = (12000000 / (9600 * 16)) * 16;
`ifdef UART_PARITY_EN
  localparam int P_BITS = 1;
`else
  localparam int P_BITS = 0;
`endif
  localparam int NB        = 10 + P_BITS;
  localparam int F         = NB * BIT;
  localparam logic [14:0] RESET_VEC = {1'b1, 6'b000000, 8'h00};

  logic clk;
  logic rstN;
  logic rx_drv;
  logic loop_sel;
  int   checks;
  int   errors;
  int   rx_done_cnt;
  int   tx_done_cnt;
  int   rx_busy_rises;
  logic rx_done_prev;
  logic tx_done_prev;
  logic rx_busy_prev;
  logic [9:0] exp_q[$];

  uart_n_if #(.DATA_BITS(8)) bus ();

  uart_n #(
    .CLOCK_RATE(12000000),
    .BAUD_RATE (9600),
    .DATA_BITS (8),
    .STOP_BITS (1),
    .PARITY    (2)
  ) dut (
    .clk (clk),
    .rstN(rstN),
    .bus (bus)
  );

  assign bus.rxIn = loop_sel ? bus.txOut : rx_drv;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] out_vec();
    return {bus.txOut, bus.txBusy, bus.txDone, bus.rxBusy, bus.rxDone, bus.rxErr, bus.rxParErr, bus.rxOut};
  endfunction

  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (P_BITS == 1 && b == 9) return ^d;
    return 1'b1;
  endfunction

  // scoreboard: pop one expected {parErr, err, data} per rxDone
  always @(negedge clk) begin
    if (bus.rxDone) begin
      rx_done_cnt++;
      check("rx_done_width", rx_done_prev, 0);
      check("rx_expected_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("rx_word", bus.rxOut, e[7:0]);
        check("rx_err", bus.rxErr, e[8]);
        check("rx_par_err", bus.rxParErr, e[9]);
      end
    end
    if (bus.txDone) begin
      tx_done_cnt++;
      check("tx_done_width", tx_done_prev, 0);
    end
    if (bus.rxBusy && !rx_busy_prev) rx_busy_rises++;
    rx_done_prev = bus.rxDone;
    tx_done_prev = bus.txDone;
    rx_busy_prev = bus.rxBusy;
  end

  // driver tasks
  task automatic rx_send(input logic [7:0] d, input logic par, input logic stop_v);
    rx_drv = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      rx_drv = d[b];
      repeat (BIT) @(negedge clk);
    end
    if (P_BITS == 1) begin
      rx_drv = par;
      repeat (BIT) @(negedge clk);
    end
    rx_drv = stop_v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic wait_rx_empty(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2 * F) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Follows one TX frame from its first START cycle; checks every bit centre and the start-bit edge.
  task automatic watch_tx(input string nm, input logic [7:0] d, input logic first, output int done_at);
    done_at = 0;
    for (int i = 1; i <= F + 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check({nm, "_busy_start"}, bus.txBusy, 1);
        check({nm, "_start_low"}, bus.txOut, 0);
        if (!first) bus.txStart = 1'b0;
      end
      if (first && i == 2000) bus.txIn = 8'hB1;
      if (i == BIT) check({nm, "_start_last"}, bus.txOut, 0);
      if (i == BIT + 1) check({nm, "_bit0_first"}, bus.txOut, d[0]);
      if ((i % BIT) == BIT / 2 && (i / BIT) < NB)
        check($sformatf("%s_bit%0d", nm, i / BIT), bus.txOut, frame_bit(d, i / BIT));
      if (bus.txDone) begin
        done_at = i;
        break;
      end
    end
  endtask

  initial begin
    int   done_at;
    int   r0;
    int   dn;
    int   busy_cyc;
    checks = 0;
    errors = 0;
    rx_done_cnt = 0;
    tx_done_cnt = 0;
    rx_busy_rises = 0;
    rx_done_prev = 1'b0;
    tx_done_prev = 1'b0;
    rx_busy_prev = 1'b0;
    rstN = 1'b0;
    rx_drv = 1'b1;
    loop_sel = 1'b1;
    bus.rxEn = 1'b1;
    bus.txEn = 1'b1;
    bus.txStart = 1'b0;
    bus.txIn = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), RESET_VEC);
    check("reset_states", {bus.tx_state_dbg, bus.rx_state_dbg}, 0);
    rstN = 1'b1;
    repeat (5) @(negedge clk);

    // loopback 0x7A with txStart held, txIn moved to 0xB1 mid-frame
    bus.txIn = 8'h7A;
    bus.txStart = 1'b1;
    exp_q.push_back({2'b00, 8'h7A});
    exp_q.push_back({2'b00, 8'hB1});
    watch_tx("f1", 8'h7A, 1'b1, done_at);
    check("f1_done_at", done_at, F + 1);
    check("f1_done_idle_high", bus.txOut, 1);
    watch_tx("f2", 8'hB1, 1'b0, done_at);
    check("f2_done_at", done_at, F + 1);
    wait_rx_empty("loopback_drained");
    check("loop_rx_done_count", rx_done_cnt, 2);

    // framing error followed by a held break
    loop_sel = 1'b0;
    repeat (BIT) @(negedge clk);
    exp_q.push_back({2'b01, 8'h55});
    rx_send(8'h55, ^8'h55, 1'b0);
    r0 = rx_busy_rises;
    repeat (3 * BIT) @(negedge clk);
    check("break_no_retrigger", rx_busy_rises, r0);
    check("break_busy_low", bus.rxBusy, 0);
    check("framing_drained", exp_q.size(), 0);
    rx_drv = 1'b1;
    repeat (50) @(negedge clk);

    // 300-clock glitch: brief rxBusy, no rxDone
    dn = rx_done_cnt;
    busy_cyc = 0;
    rx_drv = 1'b0;
    for (int i = 0; i < 1800; i++) begin
      if (i == 300) rx_drv = 1'b1;
      @(negedge clk);
      if (bus.rxBusy) busy_cyc++;
    end
    check("rearm_after_high", rx_busy_rises, r0 + 1);
    check("false_start_busy_short", (busy_cyc > 0) && (busy_cyc < 700), 1);
    check("false_start_no_done", rx_done_cnt, dn);

    // txEn dropped during data bit 4
    dn = tx_done_cnt;
    bus.txIn = 8'hFF;
    bus.txStart = 1'b1;
    @(negedge clk);
    bus.txStart = 1'b0;
    repeat (5 * BIT + 100) @(negedge clk);
    check("abort_busy_before", bus.txBusy, 1);
    bus.txEn = 1'b0;
    @(negedge clk);
    check("abort_txout_high", bus.txOut, 1);
    check("abort_busy_low", bus.txBusy, 0);
    repeat (BIT) @(negedge clk);
    check("abort_no_done", tx_done_cnt, dn);
    bus.txEn = 1'b1;

`ifdef UART_PARITY_EN
    // even parity of 0xB1 is 0; a forced 1 must be flagged
    exp_q.push_back({2'b10, 8'hB1});
    rx_send(8'hB1, 1'b1, 1'b1);
    wait_rx_empty("parity_drained");
`endif

    // asynchronous reset in the middle of a received frame
    rx_drv = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    check("pre_reset_rx_busy", bus.rxBusy, 1);
    #2 rstN = 1'b0;
    #1;
    check("async_reset_outputs", out_vec(), RESET_VEC);
    check("async_reset_states", {bus.tx_state_dbg, bus.rx_state_dbg}, 0);
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (5) @(negedge clk);
    rstN = 1'b1;
    repeat (BIT) @(negedge clk);
    dn = rx_done_cnt;
    exp_q.push_back({2'b00, 8'hA5});
    rx_send(8'hA5, ^8'hA5, 1'b1);
    wait_rx_empty("post_reset_drained");
    check("post_reset_one_done", rx_done_cnt, dn + 1);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
